// File: rtl/bu_exec_if.sv
// ---------------------------------------------------------------------------
// bu_exec_if
// Issue handshake between the branch reservation station and the branch
// execution unit.
//
//   issue_valid  RS head holds a valid entry
//   issue_data   the issued entry (opcode, tags, imm, ROB index, func3, pc)
//   fu_rdy       execution unit can accept an entry this cycle
//
// Modports:
//   master  reservation-station side (drives issue_valid/issue_data)
//   slave   execution-unit side (drives fu_rdy)
// ---------------------------------------------------------------------------
interface bu_exec_if #(
  parameter int XLEN   = 32,
  parameter int PTAG_W = 7,
  parameter int ROB_W  = 6
);

  typedef struct packed {
    logic [6:0]        opcode;
    logic [PTAG_W-1:0] pd;
    logic [PTAG_W-1:0] ps1;
    logic [PTAG_W-1:0] ps2;
    logic [XLEN-1:0]   imm;
    logic [ROB_W-1:0]  rob_index;
    logic [2:0]        func3;
    logic [XLEN-1:0]   pc;
  } rs_data_t;

  logic     issue_valid;
  rs_data_t issue_data;
  logic     fu_rdy;

  modport master (output issue_valid, output issue_data, input fu_rdy);
  modport slave  (input issue_valid, input issue_data, output fu_rdy);

endinterface

// File: rtl/bu_exec.sv
// ---------------------------------------------------------------------------
// bu_exec
// Two-stage branch execution unit. S1 holds the issued branch/jump with its
// register operands and resolves direction, target and link value; S2 holds
// the resolved result until it can complete (immediately for non-writing
// instructions, on a CDB grant for JAL/JALR with pd != 0). The front end
// predicts not-taken, so every taken branch/jump raises a redirect, which
// also kills the younger instruction sitting in S1.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   issue                 issue handshake (bu_exec_if.slave)
//   rf_raddr1/2           register file read tags (= issue_data.ps1/ps2)
//   rf_rdata1/2           same-cycle register file read data
//   cdb_req, cdb_grant    CDB arbitration for the link write
//   wb_valid/pd/data      CDB broadcast of link value and wakeup tag
//   done_valid/rob_index  completion to the ROB
//   redirect_valid/pc     one-cycle mispredict redirect
//   flush                 recovery flush (clears both stages)
//
// Optional feature (macro BU_STATS_EN): adds saturating counters
//   stat_branches (completed conditional branches) and stat_mispredicts
//   (redirect pulses).
// ---------------------------------------------------------------------------
module bu_exec #(
  parameter int XLEN   = 32,
  parameter int PTAG_W = 7,
  parameter int ROB_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  bu_exec_if.slave          issue,
  output logic [PTAG_W-1:0] rf_raddr1,
  output logic [PTAG_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic              wb_valid,
  output logic [PTAG_W-1:0] wb_pd,
  output logic [XLEN-1:0]   wb_data,
  output logic              done_valid,
  output logic [ROB_W-1:0]  done_rob_index,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic              flush
`ifdef BU_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [PTAG_W-1:0] pd;
    logic [ROB_W-1:0]  rob;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
  } s1_t;

  typedef struct packed {
    logic              taken;
    logic              writes;
`ifdef BU_STATS_EN
    logic              branch;
`endif
    logic [PTAG_W-1:0] pd;
    logic [ROB_W-1:0]  rob;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   link;
  } s2_t;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;

  logic            ex_taken;
  logic            ex_jump;
  logic            ex_branch;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] jalr_sum;
  logic            s2_leave;
  logic            s1_adv;

  assign rf_raddr1 = issue.issue_data.ps1;
  assign rf_raddr2 = issue.issue_data.ps2;

  // Resolve the S1 instruction: direction, target and whether it is a jump.
  always_comb begin
    ex_taken  = 1'b0;
    ex_jump   = 1'b0;
    ex_branch = 1'b0;
    ex_target = s1_q.pc + s1_q.imm;
    jalr_sum  = s1_q.rs1 + s1_q.imm;
    case (s1_q.opcode)
      OP_BRANCH: begin
        ex_branch = 1'b1;
        case (s1_q.func3)
          3'b000:  ex_taken = (s1_q.rs1 == s1_q.rs2);
          3'b001:  ex_taken = (s1_q.rs1 != s1_q.rs2);
          3'b100:  ex_taken = ($signed(s1_q.rs1) <  $signed(s1_q.rs2));
          3'b101:  ex_taken = ($signed(s1_q.rs1) >= $signed(s1_q.rs2));
          3'b110:  ex_taken = (s1_q.rs1 <  s1_q.rs2);
          3'b111:  ex_taken = (s1_q.rs1 >= s1_q.rs2);
          default: ex_taken = 1'b0;
        endcase
      end
      OP_JAL: begin
        ex_jump  = 1'b1;
        ex_taken = 1'b1;
      end
      OP_JALR: begin
        ex_jump   = 1'b1;
        ex_taken  = 1'b1;
        ex_target = jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1};
      end
      default: ;
    endcase
  end

  // Handshake and completion: S2 leaves unless it is waiting on the CDB;
  // a taken result kills S1 and blocks capture in the same cycle.
  always_comb begin
    s2_leave       = s2_valid_q && (!s2_q.writes || cdb_grant);
    redirect_valid = s2_leave && s2_q.taken;
    s1_adv         = s1_valid_q && (!s2_valid_q || s2_leave);
    issue.fu_rdy   = (!s1_valid_q || s1_adv) && !redirect_valid;
    done_valid     = s2_leave;
    cdb_req        = s2_valid_q && s2_q.writes;
    wb_valid       = cdb_req && cdb_grant;
    wb_pd          = s2_q.pd;
    wb_data        = s2_q.link;
    done_rob_index = s2_q.rob;
    redirect_pc    = s2_q.target;
  end

  // Next state for both stages; flush overrides advance and capture.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    if (!s2_valid_q || s2_leave) begin
      s2_valid_d = s1_valid_q && !redirect_valid;
      if (s1_valid_q) begin
        s2_d.taken  = ex_taken;
        s2_d.writes = ex_jump && (s1_q.pd != '0);
`ifdef BU_STATS_EN
        s2_d.branch = ex_branch;
`endif
        s2_d.pd     = s1_q.pd;
        s2_d.rob    = s1_q.rob;
        s2_d.target = ex_target;
        s2_d.link   = s1_q.pc + XLEN'(4);
      end
    end
    if (redirect_valid) begin
      s1_valid_d = 1'b0;
    end else if (issue.fu_rdy) begin
      s1_valid_d = issue.issue_valid;
      if (issue.issue_valid) begin
        s1_d.opcode = issue.issue_data.opcode;
        s1_d.func3  = issue.issue_data.func3;
        s1_d.pd     = issue.issue_data.pd;
        s1_d.rob    = issue.issue_data.rob_index;
        s1_d.pc     = issue.issue_data.pc;
        s1_d.imm    = issue.issue_data.imm;
        s1_d.rs1    = rf_rdata1;
        s1_d.rs2    = rf_rdata2;
      end
    end
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

`ifdef BU_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Saturating counters; deliberately blind to flush.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (s2_leave && s2_q.branch && (stat_branches_q != 32'hFFFF_FFFF))
      stat_branches_d = stat_branches_q + 32'd1;
    if (redirect_valid && (stat_mispredicts_q != 32'hFFFF_FFFF))
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: doc/bu_exec.md
Name: bu_exec

Overview:
- Branch execution unit at the downstream end of the branch reservation station's issue handshake.
- Accepts one issued branch/jump per cycle and reads operands from the physical register file.
- Resolves direction and target, broadcasts the JAL/JALR link result and wakeup tag on the CDB, and raises a one-cycle redirect on mispredict.
- Front end predicts not-taken, so every taken branch or jump is a mispredict.

Parameters:
- XLEN, 32, operand/PC/result width
- PTAG_W, 7, physical register tag width (matches wakeup ports)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- issue_valid  in  1  RS head valid (RS valid_out)
- issue_data  in  rs_data  issued entry: Opcode, pd, ps1, ps2, imm, rob_index, func3, pc
- fu_rdy  out  1  unit can accept issue this cycle
- rf_raddr1  out  PTAG_W  combinational = issue_data.ps1
- rf_raddr2  out  PTAG_W  combinational = issue_data.ps2
- rf_rdata1  in  XLEN  same-cycle read data for ps1
- rf_rdata2  in  XLEN  same-cycle read data for ps2
- cdb_req  out  1  stage-2 holds a register-writing result
- cdb_grant  in  1  CDB granted this cycle
- wb_valid  out  1  result/wakeup broadcast (= cdb_req && cdb_grant)
- wb_pd  out  PTAG_W  destination tag (drives RS regN_rdy)
- wb_data  out  XLEN  link value pc+4
- done_valid  out  1  instruction completes, to ROB
- done_rob_index  out  from rs_data  ROB index of completing instruction
- redirect_valid  out  1  one-cycle mispredict pulse
- redirect_pc  out  XLEN  correct fetch PC
- flush  in  1  pipeline flush from recovery

Behaviour:
- Two stages, each with a valid bit: S1 (execute) and S2 (writeback hold).
- Issue handshake:
  - Transfer when issue_valid && fu_rdy at a rising edge; issue_data and rf_rdata1/2 are captured into S1.
  - fu_rdy = !S1.valid || S1 advances this cycle. It is combinational and never depends on issue_valid.
- S1 computes the following, all registered into S2:
  - Opcode 1100011 (branch): taken by func3. 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU; 010/011 are treated as not-taken. target = pc + imm.
  - Opcode 1101111 (JAL): taken = 1, target = pc + imm.
  - Opcode 1100111 (JALR): taken = 1, target = (rs1 + imm) with bit 0 cleared.
  - Any other opcode: taken = 0, no write; completes normally.
  - link = pc + 4. All sums are modulo 2^XLEN.
  - writes = (JAL or JALR) && pd != 0.
- S1 advances when !S2.valid || S2 leaves.
- S2 leaves when (!writes) || cdb_grant.
- cdb_req = S2.valid && writes.
- Cycle in which S2 leaves:
  - done_valid = 1.
  - redirect_valid = taken; redirect_pc = target.
  - wb_valid = writes.
- Latency: issue accepted at edge N, S2 valid after edge N+1, completion in cycle N+1 at earliest. Throughput is 1/cycle with no CDB backpressure.
- Backpressure: S2 holds all fields stable while cdb_req && !cdb_grant; S1 then holds; fu_rdy falls once S1 is also full.
- Mispredict kill: in the cycle redirect_valid = 1, S1 is invalidated at the edge (it is younger). fu_rdy = 0 in that cycle so nothing new is captured.
- flush:
  - Outputs for the current cycle are unaffected.
  - S1.valid and S2.valid are cleared at the edge, and any issue in that cycle is dropped.
  - flush takes priority over advance and capture.
- Reset (reset == 0 at an edge, including mid-operation): both valids cleared, datapath registers zeroed.
  - Outputs after reset: fu_rdy = 1, cdb_req = 0, wb_valid = 0, done_valid = 0, redirect_valid = 0, wb_pd = 0, wb_data = 0, done_rob_index = 0, redirect_pc = 0.
- wb_pd, wb_data, done_rob_index and redirect_pc reflect S2 fields and are meaningful only with their valid signal.

Optional Feature:
- Macro BU_STATS_EN.
- When defined:
  - Adds outputs stat_branches (32b), counting completed Opcode 1100011 instructions, and stat_mispredicts (32b), counting redirect pulses.
  - Both counters saturate at 0xFFFFFFFF, clear on reset, and are unaffected by flush.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- BEQ, rf_rdata1 = rf_rdata2 = 5, pc = 0x100, imm = 0x20, issued edge N -> cycle N+1: done_valid = 1, redirect_valid = 1, redirect_pc = 0x120, wb_valid = 0.
- BLT vs BLTU with rs1 = 0xFFFFFFFF, rs2 = 1 -> BLT: redirect 1 (taken); BLTU: redirect 0, done_valid = 1.
- JALR pd = 9, rs1 = 0x203, imm = 0, pc = 0x40, cdb_grant = 1 -> wb_valid = 1, wb_pd = 9, wb_data = 0x44, redirect_pc = 0x202.
- Two back-to-back JALs with cdb_grant = 0 for 3 cycles -> cdb_req held, S2 fields stable, fu_rdy = 0 after second accept. Grant -> first completes with redirect; second killed and never reported.
- flush asserted while S1 and S2 both valid -> no done_valid, wb_valid or redirect afterwards; fu_rdy = 1 next cycle.
- reset low for one edge while S2 stalled on the CDB -> all outputs at reset values next cycle; a fresh BNE 1 vs 2 completes normally.
